mult_arb_seq: RTL and testbench

- Shares one 8×8 shift-add multiplier between two requesters, with round-robin arbitration.
- Each accepted job takes 8 add/shift iterations on a single 8-bit adder.
- The result is returned with a one-cycle done pulse tagged with the owner's ID.
- It sits between the address-generation/filter units and the multiply resource, replacing per-unit pipelined array multipliers where area matters more than throughput.

---
 rtl/mult_arb_seq_if.sv | 25 ++
 rtl/mult_arb_seq.sv | 121 ++++++++++++
 tb/tb_mult_arb_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mult_arb_seq_if.sv
// Request/result bundle between two requesters and the shared shift-add multiplier.
interface mult_arb_seq_if;
    logic       req0;
    logic [7:0] x0;
    logic [7:0] y0;
    logic       req1;
    logic [7:0] x1;
    logic [7:0] y1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [15:0] z;

    modport master (
        output req0, x0, y0, req1, x1, y1,
        input  gnt0, gnt1, busy, done, done_id, z
    );

    modport slave (
        input  req0, x0, y0, req1, x1, y1,
        output gnt0, gnt1, busy, done, done_id, z
    );
endinterface

// File: rtl/mult_arb_seq.sv
// Two-requester round-robin front end for one 8x8 unsigned shift-add multiplier.
// One product per 10 clocks: capture, 8 iterations, result presentation.
module mult_arb_seq #(
    parameter bit PRIO_INIT = 1'b0
) (
    input logic           clk,
    input logic           clr_,
    mult_arb_seq_if.slave bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  mq_q, mq_d;
    logic [7:0]  mcand_q, mcand_d;
    logic        owner_q, owner_d;
    logic        last_id_q, last_id_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done_q, done_d;
    logic        done_id_q, done_id_d;
    logic [15:0] z_q, z_d;

    logic        sel;
    logic [8:0]  sum;

    // Tie goes to whoever did not win last; a lone request wins outright.
    assign sel = (bus.req0 && bus.req1) ? ~last_id_q : bus.req1;
    assign sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : 9'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        owner_d   = owner_q;
        last_id_d = last_id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        z_d       = z_q;

        case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    mcand_d   = sel ? bus.x1 : bus.x0;
                    mq_d      = sel ? bus.y1 : bus.y0;
                    acc_d     = 8'd0;
                    cnt_d     = 3'd0;
                    owner_d   = sel;
                    last_id_d = sel;
                    gnt0_d    = ~sel;
                    gnt1_d    = sel;
                    state_d   = StRun;
                end
            end
            StRun: begin
                // Upper half accumulates; low product bits shift into mq as it drains.
                acc_d = sum[8:1];
                mq_d  = {sum[0], mq_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                z_d       = {acc_q, mq_q};
                done_d    = 1'b1;
                done_id_d = owner_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr_) begin
        if (clr_) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            acc_q     <= 8'd0;
            mq_q      <= 8'd0;
            mcand_q   <= 8'd0;
            owner_q   <= 1'b0;
            last_id_q <= ~PRIO_INIT;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            z_q       <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            owner_q   <= owner_d;
            last_id_q <= last_id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            z_q       <= z_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.z       = z_q;

endmodule

// File: tb/tb_mult_arb_seq.sv
// Directed bench for mult_arb_seq; dut1 (PRIO_INIT=1) shares stimulus with dut0.
module tb_mult_arb_seq;

    logic       clk;
    logic       clr_;
    logic       req0, req1;
    logic [7:0] x0, y0, x1, y1;

    int n_checks = 0;
    int n_pass   = 0;

    mult_arb_seq_if b0 ();
    mult_arb_seq_if b1 ();

    assign b0.req0 = req0;
    assign b0.x0   = x0;
    assign b0.y0   = y0;
    assign b0.req1 = req1;
    assign b0.x1   = x1;
    assign b0.y1   = y1;
    assign b1.req0 = req0;
    assign b1.x0   = x0;
    assign b1.y0   = y0;
    assign b1.req1 = req1;
    assign b1.x1   = x1;
    assign b1.y1   = y1;

    mult_arb_seq #(.PRIO_INIT(1'b0)) dut0 (.clk(clk), .clr_(clr_), .bus(b0.slave));
    mult_arb_seq #(.PRIO_INIT(1'b1)) dut1 (.clk(clk), .clr_(clr_), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full single-requester job on dut0, entered and left with the DUT idle.
    task automatic do_job(input bit port, input logic [7:0] xa, input logic [7:0] ya,
                          input logic [15:0] exp);
        if (!port) begin
            req0 = 1'b1; x0 = xa; y0 = ya;
        end else begin
            req1 = 1'b1; x1 = xa; y1 = ya;
        end
        step();
        check("job_gnt0", b0.gnt0, 32'(!port));
        check("job_gnt1", b0.gnt1, 32'(port));
        check("job_busy_c0", b0.busy, 1);
        if (!port) req0 = 1'b0;
        else req1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("job_busy_run", b0.busy, 1);
            check("job_nodone_run", b0.done, 0);
        end
        step();
        check("job_done", b0.done, 1);
        check("job_done_id", b0.done_id, 32'(port));
        check("job_z", b0.z, 32'(exp));
        check("job_busy_c9", b0.busy, 0);
        step();
        check("job_done_clr", b0.done, 0);
        check("job_z_hold", b0.z, 32'(exp));
    endtask

    logic [7:0]  bb_x [3];
    logic [7:0]  bb_y [3];
    logic [15:0] bb_z [3];

    initial begin
        clr_ = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0;
        step();
        step();
        check("rst_gnt0", b0.gnt0, 0);
        check("rst_gnt1", b0.gnt1, 0);
        check("rst_busy", b0.busy, 0);
        check("rst_done", b0.done, 0);
        check("rst_done_id", b0.done_id, 0);
        check("rst_z", b0.z, 0);
        clr_ = 1'b0;

        // Single request and corner operands.
        do_job(1'b0, 8'd3, 8'd5, 16'd15);
        do_job(1'b1, 8'd255, 8'd255, 16'hFE01);
        do_job(1'b0, 8'd0, 8'd200, 16'd0);
        do_job(1'b0, 8'd128, 8'd2, 16'd256);

        // Back-to-back on req0; operands change right after each grant.
        bb_x[0] = 8'd10;  bb_y[0] = 8'd11; bb_z[0] = 16'd110;
        bb_x[1] = 8'd20;  bb_y[1] = 8'd30; bb_z[1] = 16'd600;
        bb_x[2] = 8'd255; bb_y[2] = 8'd1;  bb_z[2] = 16'd255;
        req0 = 1'b1; x0 = bb_x[0]; y0 = bb_y[0];
        for (int j = 0; j < 3; j++) begin
            step();
            check("b2b_gnt0", b0.gnt0, 1);
            if (j < 2) begin
                x0 = bb_x[j+1]; y0 = bb_y[j+1];
            end else begin
                req0 = 1'b0; x0 = 8'hAA; y0 = 8'h55;
            end
            for (int k = 1; k <= 8; k++) begin
                step();
                check("b2b_nognt", b0.gnt0, 0);
            end
            step();
            check("b2b_done", b0.done, 1);
            check("b2b_z", b0.z, 32'(bb_z[j]));
        end

        // Reset in cycle 4 of a 7 x 9 job.
        step();
        req0 = 1'b1; x0 = 8'd7; y0 = 8'd9;
        step();
        check("mid_gnt0", b0.gnt0, 1);
        req0 = 1'b0;
        repeat (4) step();
        #1 clr_ = 1'b1;
        #1;
        check("mid_busy", b0.busy, 0);
        check("mid_z", b0.z, 0);
        check("mid_done", b0.done, 0);
        step();
        check("mid_done_held", b0.done, 0);
        clr_ = 1'b0;

        // Ties after reset: dut0 starts with req0, dut1 with req1.
        req0 = 1'b1; x0 = 8'd2; y0 = 8'd3;
        req1 = 1'b1; x1 = 8'd4; y1 = 8'd5;
        for (int j = 0; j < 3; j++) begin
            bit o0;
            bit o1;
            o0 = (j == 1);
            o1 = (j != 1);
            step();
            check("tie0_gnt0", b0.gnt0, 32'(!o0));
            check("tie0_gnt1", b0.gnt1, 32'(o0));
            check("tie1_gnt1", b1.gnt1, 32'(o1));
            if (j == 2) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            repeat (8) step();
            step();
            check("tie0_done", b0.done, 1);
            check("tie0_id", b0.done_id, 32'(o0));
            check("tie0_z", b0.z, o0 ? 32'd20 : 32'd6);
            check("tie1_id", b1.done_id, 32'(o1));
            check("tie1_z", b1.z, o1 ? 32'd20 : 32'd6);
        end

        // req1 arrives in cycle 3 of a req0 job.
        step();
        req0 = 1'b1; x0 = 8'd6; y0 = 8'd7;
        step();
        check("late_gnt0", b0.gnt0, 1);
        req0 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 3) begin
                req1 = 1'b1; x1 = 8'd9; y1 = 8'd9;
            end
            check("late_nognt1", b0.gnt1, 0);
        end
        step();
        check("late_done0", b0.done, 1);
        check("late_id0", b0.done_id, 0);
        check("late_z0", b0.z, 42);
        check("late_nognt1_c9", b0.gnt1, 0);
        step();
        check("late_gnt1", b0.gnt1, 1);
        req1 = 1'b0;
        repeat (8) step();
        step();
        check("late_done1", b0.done, 1);
        check("late_id1", b0.done_id, 1);
        check("late_z1", b0.z, 81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
